// File: rtl/io_bus_bridge.sv
// io_bus_bridge: nibble-bus bridge for the 4-bit CPU.
// Serves a 16-nibble I/O window at IO_BASE (GPIO, prescaled timer, scratch)
// and passes every other address through to external memory.
module io_bus_bridge #(
  parameter logic [10:0] IO_BASE = 11'h7F0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [3:0]  cpu_dout,
  output logic [3:0]  cpu_din,
  output logic [10:0] ext_addr,
  output logic        ext_we,
  output logic [3:0]  ext_wdata,
  input  logic [3:0]  ext_rdata,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  logic       rw_q;
  logic       match_q;
  logic [7:0] gpi_p0;
  logic [7:0] gpi_p1;
  logic [7:0] pre;
  logic [7:0] presc;
  logic [7:0] cnt;
  logic [3:0] shadow;
  logic       en;
  logic       ovf;
  logic       irq_en;
  logic [3:0] scratch;

  logic       io_hit;
  logic [3:0] off;
  logic       commit;
  logic       io_wr;
  logic       rd_match;
  logic       tick;
  logic       ovf_set;
  logic [3:0] io_rdata;

  assign io_hit    = (cpu_addr[10:4] == IO_BASE[10:4]);
  assign off       = cpu_addr[3:0];
  // Data is only valid in the second high cycle of cpu_rw.
  assign commit    = cpu_rw & rw_q;
  assign io_wr     = commit & io_hit;
  assign rd_match  = io_hit & (off == 4'd6) & ~cpu_rw;
  assign tick      = en & (presc == pre);
  assign ovf_set   = tick & (cnt == 8'hFF);

  assign ext_addr  = cpu_addr;
  assign ext_wdata = cpu_dout;
  assign ext_we    = commit & ~io_hit;
  assign cpu_din   = io_hit ? io_rdata : ext_rdata;
  assign timer_irq = ovf & irq_en;

  // Local register read mux for the I/O window.
  always_comb begin
    io_rdata = 4'h0;
    case (off)
      4'h0:    io_rdata = gpio_out[3:0];
      4'h1:    io_rdata = gpio_out[7:4];
      4'h2:    io_rdata = gpi_p1[3:0];
      4'h3:    io_rdata = gpi_p1[7:4];
      4'h4:    io_rdata = pre[3:0];
      4'h5:    io_rdata = pre[7:4];
      4'h6:    io_rdata = cnt[3:0];
      4'h7:    io_rdata = shadow;
      4'h8:    io_rdata = {1'b0, irq_en, ovf, en};
      4'h9:    io_rdata = scratch;
      default: io_rdata = 4'h0;
    endcase
  end

  // Bus edge trackers: write-strobe history and CNT-low read history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      rw_q    <= cpu_rw;
      match_q <= rd_match;
    end
  end

  // Two-flop synchroniser on the asynchronous GPIO pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpi_p0 <= 8'h00;
      gpi_p1 <= 8'h00;
    end else begin
      gpi_p0 <= gpio_in;
      gpi_p1 <= gpi_p0;
    end
  end

  // Register file and timer; later assignments give writes priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out <= 8'h00;
      pre      <= 8'h00;
      presc    <= 8'h00;
      cnt      <= 8'h00;
      shadow   <= 4'h0;
      en       <= 1'b0;
      ovf      <= 1'b0;
      irq_en   <= 1'b0;
      scratch  <= 4'h0;
    end else begin
      if (tick) begin
        presc <= 8'h00;
        cnt   <= cnt + 8'd1;
      end else if (en) begin
        presc <= presc + 8'd1;
      end
      if (rd_match & ~match_q) shadow <= cnt[7:4];
      if (io_wr) begin
        case (off)
          4'h0: gpio_out[3:0] <= cpu_dout;
          4'h1: gpio_out[7:4] <= cpu_dout;
          4'h4: begin pre[3:0] <= cpu_dout; presc <= 8'h00; end
          4'h5: begin pre[7:4] <= cpu_dout; presc <= 8'h00; end
          4'h6: begin cnt <= 8'h00; presc <= 8'h00; end
          4'h8: begin
            en     <= cpu_dout[0];
            irq_en <= cpu_dout[2];
            if (cpu_dout[1]) ovf <= 1'b0;
          end
          4'h9: scratch <= cpu_dout;
          default: ;
        endcase
      end
      // A wrap in the same cycle as a clear request keeps the flag set.
      if (ovf_set) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: directed bus transactions with
// literal expectations, plus a per-cycle comparison against a behavioural model.
module tb_io_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic [10:0] cpu_addr;
  logic        cpu_rw;
  logic [3:0]  cpu_dout;
  logic [3:0]  cpu_din;
  logic [10:0] ext_addr;
  logic        ext_we;
  logic [3:0]  ext_wdata;
  logic [3:0]  ext_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int total;
  int passed;

  io_bus_bridge #(.IO_BASE(11'h7F0)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .ext_addr(ext_addr),
    .ext_we(ext_we), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic       live;
  logic [7:0] m_gpo;
  int         m_pre, m_presc, m_cnt;
  logic [3:0] m_shadow, m_scr;
  logic       m_en, m_ovf, m_irqen;
  logic       m_prev_rw, m_prev_rd6;
  logic [7:0] m_pin1, m_pin2;

  function automatic bit in_window(input logic [10:0] a);
    return (a >> 4) == 11'h07F;
  endfunction

  function automatic logic [3:0] model_din(input logic [10:0] a, input logic [3:0] ext);
    int o;
    logic [7:0] v;
    o = int'(a[3:0]);
    if (!in_window(a)) return ext;
    case (o)
      0: return m_gpo[3:0];
      1: return m_gpo[7:4];
      2: return m_pin2[3:0];
      3: return m_pin2[7:4];
      4: begin v = 8'(m_pre); return v[3:0]; end
      5: begin v = 8'(m_pre); return v[7:4]; end
      6: begin v = 8'(m_cnt); return v[3:0]; end
      7: return m_shadow;
      8: return {1'b0, m_irqen, m_ovf, m_en};
      9: return m_scr;
      default: return 4'h0;
    endcase
  endfunction

  initial live = 1'b0;

  always @(posedge clk) begin : model
    int o, n_pre, n_presc, n_cnt;
    logic [7:0] n_gpo, pv;
    logic [3:0] n_sh, n_scr;
    logic n_en, n_ovf, n_irq, wraps, wr, rd6;
    if (!rst_n) begin
      live <= 1'b1;
      m_gpo <= 8'h00; m_pre <= 0; m_presc <= 0; m_cnt <= 0;
      m_shadow <= 4'h0; m_scr <= 4'h0; m_en <= 1'b0; m_ovf <= 1'b0;
      m_irqen <= 1'b0; m_prev_rw <= 1'b0; m_prev_rd6 <= 1'b0;
      m_pin1 <= 8'h00; m_pin2 <= 8'h00;
    end else begin
      o = int'(cpu_addr[3:0]);
      wr  = cpu_rw && m_prev_rw && in_window(cpu_addr);
      rd6 = !cpu_rw && in_window(cpu_addr) && o == 6;
      n_gpo = m_gpo; n_pre = m_pre; n_presc = m_presc; n_cnt = m_cnt;
      n_sh = m_shadow; n_scr = m_scr; n_en = m_en; n_ovf = m_ovf; n_irq = m_irqen;
      wraps = 1'b0;
      // prescaler counts modulo PRE+1; each rollover advances CNT modulo 256
      if (m_en) begin
        n_presc = (m_presc + 1) % (m_pre + 1);
        if (n_presc == 0) begin
          n_cnt = (m_cnt + 1) % 256;
          wraps = (n_cnt == 0);
        end
      end
      if (rd6 && !m_prev_rd6) n_sh = 4'(m_cnt / 16);
      if (wr) begin
        pv = 8'(m_pre);
        case (o)
          0: n_gpo[3:0] = cpu_dout;
          1: n_gpo[7:4] = cpu_dout;
          4: begin pv[3:0] = cpu_dout; n_pre = int'(pv); n_presc = 0; end
          5: begin pv[7:4] = cpu_dout; n_pre = int'(pv); n_presc = 0; end
          6: begin n_cnt = 0; n_presc = 0; end
          8: begin n_en = cpu_dout[0]; n_irq = cpu_dout[2]; if (cpu_dout[1]) n_ovf = 1'b0; end
          9: n_scr = cpu_dout;
          default: ;
        endcase
      end
      if (wraps) n_ovf = 1'b1;
      m_gpo <= n_gpo; m_pre <= n_pre; m_presc <= n_presc; m_cnt <= n_cnt;
      m_shadow <= n_sh; m_scr <= n_scr; m_en <= n_en; m_ovf <= n_ovf; m_irqen <= n_irq;
      m_prev_rw <= cpu_rw; m_prev_rd6 <= rd6;
      m_pin1 <= gpio_in; m_pin2 <= m_pin1;
    end
  end

  // per-cycle comparison against the model, on the inactive edge
  always @(negedge clk) begin
    if (live) begin
      chk("m_ext_we", int'(ext_we), int'(cpu_rw && m_prev_rw && !in_window(cpu_addr)));
      chk("m_ext_addr", int'(ext_addr), int'(cpu_addr));
      chk("m_ext_wdata", int'(ext_wdata), int'(cpu_dout));
      chk("m_gpio_out", int'(gpio_out), int'(m_gpo));
      chk("m_timer_irq", int'(timer_irq), int'(m_ovf && m_irqen));
      if (!cpu_rw) chk("m_cpu_din", int'(cpu_din), int'(model_din(cpu_addr, ext_rdata)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [3:0] d);
    cpu_rw = 1'b1; cpu_addr = a; cpu_dout = ~d;
    #1 chk("we_first_cycle", int'(ext_we), 0);
    step();
    cpu_dout = d;
    #1 chk("we_commit_cycle", int'(ext_we), int'(!in_window(a)));
    step();
    cpu_rw = 1'b0;
    step();
  endtask

  task automatic rd(input string name, input logic [10:0] a, input logic [3:0] exp);
    cpu_rw = 1'b0; cpu_addr = a;
    #1 chk(name, int'(cpu_din), int'(exp));
    step();
  endtask

  initial begin
    int k;
    logic [3:0] cnt_exp [6];
    total = 0; passed = 0;
    rst_n = 1'b0; cpu_rw = 1'b0; cpu_addr = 11'h000; cpu_dout = 4'h0;
    ext_rdata = 4'h0; gpio_in = 8'h00;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_gpio_out", int'(gpio_out), 0);
    chk("rst_timer_irq", int'(timer_irq), 0);
    chk("rst_ext_we", int'(ext_we), 0);
    rd("rst_ctrl", 11'h7F8, 4'h0);
    rd("rst_cnt", 11'h7F6, 4'h0);

    // GPIO output latches
    wr(11'h7F0, 4'hA);
    wr(11'h7F1, 4'h5);
    chk("gpo_5a", int'(gpio_out), 8'h5A);
    rd("gpo_lo_rd", 11'h7F0, 4'hA);

    // external pass-through
    cpu_rw = 1'b1; cpu_addr = 11'h123; cpu_dout = 4'h0;
    #1 chk("ext_we_c1", int'(ext_we), 0);
    step();
    cpu_dout = 4'h7;
    #1;
    chk("ext_we_c2", int'(ext_we), 1);
    chk("ext_addr", int'(ext_addr), 11'h123);
    chk("ext_wdata", int'(ext_wdata), 4'h7);
    step();
    cpu_rw = 1'b0;
    #1 chk("ext_we_after", int'(ext_we), 0);
    step();
    ext_rdata = 4'h9;
    rd("ext_read", 11'h123, 4'h9);

    // unmapped offsets and scratch
    wr(11'h7FA, 4'hF);
    rd("unmapped_a", 11'h7FA, 4'h0);
    rd("unmapped_f", 11'h7FF, 4'h0);
    wr(11'h7F9, 4'hC);
    rd("scratch", 11'h7F9, 4'hC);

    // GPI synchroniser latency
    gpio_in = 8'h3C;
    rd("gpi_lo_c1", 11'h7F2, 4'h0);
    rd("gpi_hi_c2", 11'h7F3, 4'h0);
    rd("gpi_lo_c3", 11'h7F2, 4'hC);
    rd("gpi_hi_c4", 11'h7F3, 4'h3);

    // timer: PRE=2, EN and IRQ_EN
    wr(11'h7F4, 4'h2);
    wr(11'h7F5, 4'h0);
    wr(11'h7F8, 4'h5);
    cnt_exp = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h2};
    for (int i = 0; i < 6; i++) rd("cnt_every3", 11'h7F6, cnt_exp[i]);
    k = 7;
    while (!timer_irq && k < 1000) begin
      step();
      k++;
    end
    chk("irq_after_768", k, 768);
    rd("ctrl_ovf_set", 11'h7F8, 4'h7);
    wr(11'h7F8, 4'h3);
    chk("irq_cleared", int'(timer_irq), 0);
    rd("ctrl_ovf_clr", 11'h7F8, 4'h1);

    // shadow coherence with PRE=0
    wr(11'h7F4, 4'h0);
    wr(11'h7F5, 4'h0);
    wr(11'h7F6, 4'h0);
    cpu_addr = 11'h7F9;
    for (int i = 0; i < 14; i++) step();
    rd("cnt_lo_0f", 11'h7F6, 4'hF);
    rd("shadow_hi", 11'h7F7, 4'h0);
    rd("cnt_lo_11", 11'h7F6, 4'h1);

    // reset during a running timer and a pending write
    cpu_rw = 1'b1; cpu_addr = 11'h7F9; cpu_dout = 4'h0;
    step();
    rst_n = 1'b0; cpu_dout = 4'h3;
    step();
    rst_n = 1'b1; cpu_rw = 1'b0;
    #1;
    chk("rst2_gpio_out", int'(gpio_out), 0);
    chk("rst2_timer_irq", int'(timer_irq), 0);
    rd("rst2_scratch", 11'h7F9, 4'h0);
    rd("rst2_ctrl", 11'h7F8, 4'h0);
    rd("rst2_cnt", 11'h7F6, 4'h0);
    rd("rst2_pre", 11'h7F4, 4'h0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_bus_bridge.md
# io_bus_bridge

Memory-mapped bus bridge directly downstream of the 4-bit CPU's nibble bus (11-bit address, read/write strobe, 4-bit data in/out). It decodes a 16-nibble I/O window at IO_BASE and serves it locally: GPIO output latches, a synchronised GPIO input port, an 8-bit prescaled timer with overflow flag, and a scratch nibble. Every other address passes straight through to the external program/data memory port. Read data returns combinationally, matching the CPU's one-cycle "address out, sample next edge" read timing.

## Interface
- IO_BASE, 11'h7F0, base of the I/O window; low 4 bits must be 0.
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- cpu_addr  in  11  CPU bus address (registered in CPU).
- cpu_rw  in  1  1 = write, 0 = read.
- cpu_dout  in  4  CPU write data.
- cpu_din  out  4  read data to CPU, combinational.
- ext_addr  out  11  external memory address, equal to cpu_addr.
- ext_we  out  1  external write strobe, one or more cycles.
- ext_wdata  out  4  equal to cpu_dout.
- ext_rdata  in  4  external memory read data.
- gpio_in  in  8  asynchronous input pins.
- gpio_out  out  8  output latch.
- timer_irq  out  1  overflow flag AND irq enable.

## Operation
- io_hit = (cpu_addr[10:4] == IO_BASE[10:4]); off = cpu_addr[3:0].
- Write commit: a CPU write holds cpu_rw high for 2 cycles. cpu_addr is valid in both cycles; cpu_dout is valid only in the second. rw_q is cpu_rw registered. commit = cpu_rw & rw_q. Every commit cycle writes, and repeated writes of identical data are harmless.
- ext_we = commit & !io_hit. Register writes happen at the clock edge ending a commit cycle with io_hit.
- cpu_din = io_hit ? io_rdata(off) : ext_rdata. The value while cpu_rw=1 is unspecified.
- Register map (offset, access, meaning):
  - 0 RW: GPO[3:0].
  - 1 RW: GPO[7:4].
  - 2 R: GPI[3:0].
  - 3 R: GPI[7:4].
  - 4 RW: PRE[3:0].
  - 5 RW: PRE[7:4].
  - 6 R/W: CNT[3:0] live. Any write clears CNT and the prescaler to 0.
  - 7 R: CNT_HI shadow.
  - 8 RW: CTRL. bit0 EN, bit1 OVF (read 1 = set; write 1 = clear), bit2 IRQ_EN, bit3 reads 0.
  - 9 RW: SCRATCH.
  - A-F: read 0, writes ignored.
- GPI: two-flop synchroniser on gpio_in; registers read the second flop.
- Timer, when EN=1: the 8-bit prescaler increments each cycle. When prescaler == PRE, the prescaler goes to 0 and CNT increments. PRE=0 means CNT increments every cycle. CNT wraps 0xFF→0x00 and sets OVF. When EN=0, prescaler and CNT hold.
- Writing PRE_LO or PRE_HI also zeroes the prescaler.
- Shadow: on the first cycle of (io_hit & off==6 & !cpu_rw), i.e. match & !match_q, the shadow loads the CNT[7:4] value current that cycle. A read of LO then HI therefore returns a coherent 8-bit value.
- Simultaneous OVF set and write-1-clear: set wins.
- Simultaneous CNT increment and CNT-clear write: clear wins.

## Timing
- Reset (rst_n=0 at an edge) zeroes: gpio_out, PRE, prescaler, CNT, shadow, CTRL, SCRATCH, sync flops, rw_q, match_q. Then timer_irq=0 and ext_we=0. cpu_din, ext_addr and ext_wdata follow their inputs combinationally.
- Reset mid-write: rw_q clears, so a write in flight is dropped. Reset mid-count loses the count.
- Read latency 0: cpu_din is valid in the same cycle as cpu_addr.
- Write latency: a register is updated the cycle after the second high cycle of cpu_rw.
- GPI latency: 2 clocks from pin to readable.
- timer_irq: asserted the cycle after the wrapping edge (registered OVF). It stays high until OVF is cleared or IRQ_EN=0.

## Test plan
- Write 0xA to offset 0 and 0x5 to offset 1 (rw high 2 cycles each) -> gpio_out=0x5A. Verify ext_we stays 0 throughout.
- Write to address 0x123, data 0x7 -> ext_we high exactly in the second rw cycle, ext_addr=0x123, ext_wdata=0x7. Read 0x123 with ext_rdata=0x9 -> cpu_din=0x9.
- gpio_in=0x3C -> reads of offsets 2/3 return 0xC/0x3 from the 3rd cycle after the change, and old values before that.
- PRE=0x02, EN=1 -> CNT increments every 3 cycles. After 768 cycles CNT wraps and OVF=1; with IRQ_EN=1, timer_irq=1. Write 0x2|EN to CTRL -> OVF=0, timer_irq=0.
- PRE=0, CNT at 0x0F: read LO -> 0xF. Next cycle CNT=0x10; read HI -> shadow 0x0, not 0x1.
- Assert rst_n=0 during a timer run and a pending write -> all registers 0 the next cycle, and the write does not commit.
